// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 8-way round-robin mux arbiter.
package mux_arb_pkg;

  // Arbiter FSM states
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NREQ             = 8;
  localparam int SEL_W            = 3;
  localparam int HOLD_MAX_DEFAULT = 4;

  // One-hot decode of a requester index into a grant vector
  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first asserted request searching
// ptr, ptr+1, ... ptr+7 with wrap modulo 8.
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [SEL_W-1:0] idx_s;

  // Scan from the farthest candidate back to ptr so the nearest hit wins
  always_comb begin
    winner = ptr;
    idx_s  = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_s = ptr + SEL_W'(k);
      if (req[idx_s]) begin
        winner = idx_s;
      end else begin
        winner = winner;
      end
    end
  end

  // Any request pending at all
  always_comb begin
    any = |req;
  end

endmodule

// File: rtl/mux8_arbiter.sv
// Round-robin controller driving the select pins of a shared 8:1 x 4-bit
// word mux. Holds a grant for at most HOLD_MAX accepted beats, then rotates.
module mux8_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            ready,
  output logic            s2,
  output logic            s1,
  output logic            s0,
  output logic [NREQ-1:0] gnt,
  output logic            valid,
  output logic            busy
);

  localparam logic [3:0] BEAT_LAST = 4'(HOLD_MAX - 1);

  state_t           state_r;
  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W-1:0] sel_r;
  logic [3:0]       beat_cnt_r;
  logic [NREQ-1:0]  gnt_r;
  logic             busy_r;

  logic [SEL_W-1:0] winner_s;
  logic             any_s;
  logic             owner_req_s;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (ptr_r),
    .winner (winner_s),
    .any    (any_s)
  );

  // Live request of the current (or last) winner
  always_comb begin
    owner_req_s = req[sel_r];
  end

  // Word is valid only while granted and the owner still requests
  always_comb begin
    valid = busy_r & owner_req_s;
  end

  // Select pins come straight from the registered winner
  always_comb begin
    {s2, s1, s0} = sel_r;
    gnt          = gnt_r;
    busy         = busy_r;
  end

  // Arbiter FSM: arbitration, beat counting, release and priority rotation
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      ptr_r      <= 3'd0;
      sel_r      <= 3'd0;
      beat_cnt_r <= 4'd0;
      gnt_r      <= 8'd0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            state_r    <= GRANT;
            sel_r      <= winner_s;
            gnt_r      <= onehot(winner_s);
            beat_cnt_r <= 4'd0;
            busy_r     <= 1'b1;
          end else begin
            state_r    <= IDLE;
          end
        end
        GRANT: begin
          if (!owner_req_s) begin
            // Release wins over a simultaneous accept: no beat counted
            state_r <= IDLE;
            ptr_r   <= sel_r + 3'd1;
            gnt_r   <= 8'd0;
            busy_r  <= 1'b0;
          end else if (ready) begin
            if (beat_cnt_r == BEAT_LAST) begin
              state_r <= IDLE;
              ptr_r   <= sel_r + 3'd1;
              gnt_r   <= 8'd0;
              busy_r  <= 1'b0;
            end else begin
              beat_cnt_r <= beat_cnt_r + 4'd1;
            end
          end else begin
            // Stalled by downstream: hold everything
            state_r <= GRANT;
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= 8'd0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_arbiter.sv
// Self-checking bench for mux8_arbiter: vector table, directed corner
// sequences and a reference-model scoreboard.
module tb_mux8_arbiter;

  localparam int HOLD = 4;

  logic       clock;
  logic       reset;
  logic [7:0] req;
  logic       ready;
  logic       s2, s1, s0;
  logic [7:0] gnt;
  logic       valid;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  mux8_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .ready (ready),
    .s2    (s2),
    .s1    (s1),
    .s0    (s0),
    .gnt   (gnt),
    .valid (valid),
    .busy  (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] req;
    logic       ready;
    logic       rst;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       busy;
  } exp_t;

  exp_t sb[$];

  // reference model state
  logic       m_busy;
  logic [2:0] m_sel;
  logic [2:0] m_ptr;
  logic [3:0] m_beat;

  logic pre_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] model_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] w;
    logic       found;
    w = p;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!found && r[(int'(p) + k) % 8]) begin
        w = 3'((int'(p) + k) % 8);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  task automatic model_update(input logic [7:0] r, input logic rd, input logic rs);
    if (rs) begin
      m_busy = 1'b0; m_sel = 3'd0; m_ptr = 3'd0; m_beat = 4'd0;
    end else if (!m_busy) begin
      if (r != 8'd0) begin
        m_sel  = model_pick(r, m_ptr);
        m_busy = 1'b1;
        m_beat = 4'd0;
      end
    end else if (!r[m_sel]) begin
      m_busy = 1'b0;
      m_ptr  = m_sel + 3'd1;
    end else if (rd) begin
      if (int'(m_beat) == HOLD - 1) begin
        m_busy = 1'b0;
        m_ptr  = m_sel + 3'd1;
      end else begin
        m_beat = m_beat + 4'd1;
      end
    end
  endtask

  // One clock: drive at negedge, predict, compare #1 after the rising edge
  task automatic step(input logic [7:0] r, input logic rd, input logic rs);
    exp_t e;
    exp_t got;
    @(negedge clock);
    req   = r;
    ready = rd;
    reset = rs;
    #1;
    pre_valid = valid;
    model_update(r, rd, rs);
    e.gnt   = m_busy ? (8'd1 << m_sel) : 8'd0;
    e.sel   = m_sel;
    e.valid = m_busy & r[m_sel];
    e.busy  = m_busy;
    sb.push_back(e);
    @(posedge clock);
    #1;
    got = sb.pop_front();
    check("scoreboard", 32'({gnt, s2, s1, s0, valid, busy}),
          32'({got.gnt, got.sel, got.valid, got.busy}));
  endtask

  vec_t tab[9];
  int   wins[$];
  int   run_len;
  logic prev_busy;
  int   beats;
  logic done;

  initial begin
    reset = 1'b1; req = 8'd0; ready = 1'b0; pre_valid = 1'b0;
    m_busy = 1'b0; m_sel = 3'd0; m_ptr = 3'd0; m_beat = 4'd0;

    // single requester 3, HOLD=4 beats, one idle cycle, re-grant, release
    tab[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tab[1] = '{8'h08, 1'b1, 1'b0, 8'h08, 3'd3, 1'b1, 1'b1};
    tab[2] = '{8'h08, 1'b1, 1'b0, 8'h08, 3'd3, 1'b1, 1'b1};
    tab[3] = '{8'h08, 1'b1, 1'b0, 8'h08, 3'd3, 1'b1, 1'b1};
    tab[4] = '{8'h08, 1'b1, 1'b0, 8'h08, 3'd3, 1'b1, 1'b1};
    tab[5] = '{8'h08, 1'b1, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0};
    tab[6] = '{8'h08, 1'b1, 1'b0, 8'h08, 3'd3, 1'b1, 1'b1};
    tab[7] = '{8'h00, 1'b1, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0};
    tab[8] = '{8'h00, 1'b1, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0};

    for (int i = 0; i < 9; i++) begin
      step(tab[i].req, tab[i].ready, tab[i].rst);
      check($sformatf("table_row%0d", i), 32'({gnt, s2, s1, s0, valid, busy}),
            32'({tab[i].gnt, tab[i].sel, tab[i].valid, tab[i].busy}));
      if (i == 5) check("single_ptr_after_hold", 32'(dut.ptr_r), 32'd4);
    end

    // rotation with all requesters active
    step(8'h00, 1'b1, 1'b1);
    prev_busy = 1'b0;
    run_len = 0;
    for (int i = 0; i < 41; i++) begin
      step(8'hFF, 1'b1, 1'b0);
      if (busy && !prev_busy) wins.push_back(int'({s2, s1, s0}));
      if (busy) run_len++;
      if (!busy && prev_busy) begin
        check("rotate_grant_len", 32'(run_len), 32'(HOLD));
        run_len = 0;
      end
      if (!busy && !prev_busy && i > 0) check("rotate_single_idle", 32'(busy), 32'd1);
      prev_busy = busy;
    end
    check("rotate_grant_count", 32'(wins.size()), 32'd9);
    for (int i = 0; i < 9 && i < wins.size(); i++)
      check($sformatf("rotate_winner%0d", i), 32'(wins[i]), 32'(i % 8));

    // early release of requester 5 after two accepted beats
    step(8'h00, 1'b1, 1'b1);
    step(8'h20, 1'b1, 1'b0);
    step(8'h20, 1'b1, 1'b0);
    step(8'h20, 1'b1, 1'b0);
    check("release_beats_before", 32'(dut.beat_cnt_r), 32'd2);
    step(8'h00, 1'b1, 1'b0);
    check("release_valid_same_cycle", 32'(pre_valid), 32'd0);
    check("release_gnt", 32'(gnt), 32'h00);
    check("release_beat_final", 32'(dut.beat_cnt_r), 32'd2);
    check("release_ptr", 32'(dut.ptr_r), 32'd6);

    // ten-cycle stall during a grant to requester 2
    step(8'h00, 1'b1, 1'b1);
    step(8'h04, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(8'h04, 1'b0, 1'b0);
      check("stall_state", 32'({gnt, s2, s1, s0, dut.beat_cnt_r}), 32'({8'h04, 3'd2, 4'd0}));
    end
    beats = 0;
    done  = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      step(8'h04, 1'b1, 1'b0);
      if (pre_valid) beats++;
      if (!busy) done = 1'b1;
    end
    check("stall_released", 32'(done), 32'd1);
    check("stall_beats_after", 32'(beats), 32'(HOLD));

    // priority wrap: grant 6, release, then requesters 0 and 1 compete
    step(8'h00, 1'b1, 1'b1);
    step(8'h40, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    check("wrap_ptr", 32'(dut.ptr_r), 32'd7);
    step(8'h03, 1'b1, 1'b0);
    check("wrap_winner", 32'({gnt, s2, s1, s0}), 32'({8'h01, 3'd0}));

    // reset during beat 2 of a grant to requester 4
    step(8'h00, 1'b1, 1'b1);
    step(8'h10, 1'b1, 1'b0);
    step(8'h10, 1'b1, 1'b0);
    step(8'h10, 1'b1, 1'b1);
    check("rst_mid_outputs", 32'({gnt, s2, s1, s0, valid, busy}), 32'd0);
    check("rst_mid_ptr", 32'(dut.ptr_r), 32'd0);
    check("rst_mid_beat", 32'(dut.beat_cnt_r), 32'd0);

    // random traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      step(8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mux8_arbiter.md
# mux8_arbiter

Round-robin controller that shares the 8:1 × 4-bit word multiplexer among eight requesters. It watches a one-hot-capable request vector and picks one winner. It drives the mux select lines S2/S1/S0 and a one-hot grant, then holds the grant for a bounded number of accepted beats before rotating priority. It sits directly in front of the mux select pins. The mux output F goes to the downstream consumer, which uses the Valid/Ready pair below.

## Interface
- HOLD_MAX, 4: maximum accepted beats per grant; legal range 1..15.

- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Req  in  8  Req[i] high = requester i wants the shared mux output.
- Ready  in  1  downstream accepts the current word this cycle.
- S2, S1, S0  out  1 each  registered mux select; {S2,S1,S0} = index of the current or last winner.
- Gnt  out  8  registered one-hot grant; all-zero when no grant is active.
- Valid  out  1  word on mux output F is valid for the downstream consumer.
- Busy  out  1  high while in GRANT state.

## Operation
- State machine with two states:
  - IDLE: Gnt=0, Valid=0, Busy=0.
  - GRANT: Busy=1.
- Priority pointer Ptr (3 bits) names the highest-priority requester. The winner is the first i with Req[i]=1, searching Ptr, Ptr+1, …, Ptr+7, with wrap modulo 8.
- IDLE → GRANT when any Req bit is high. On that edge:
  - register the winner into {S2,S1,S0}
  - set Gnt = 1<<winner
  - clear BeatCnt (4 bits).
- In GRANT:
  - Valid = Req[winner] (combinational from registered winner and live Req).
  - A beat is accepted when Valid && Ready; BeatCnt increments on each accepted beat.
- GRANT → IDLE on either condition:
  - (a) Req[winner]=0 (requester released); no beat is counted that cycle.
  - (b) an accepted beat with BeatCnt == HOLD_MAX-1.
- On every GRANT → IDLE edge: Ptr ← winner+1 (mod 8, 7 wraps to 0) and Gnt ← 0.
- {S2,S1,S0} holds its value in IDLE. It changes only on IDLE → GRANT, so the mux never glitches during a transfer.
- Other requesters' Req changes during GRANT have no effect until the next arbitration.
- Ready low stalls: the state is held, BeatCnt is held, and there is no timeout.
- Req=0 in IDLE: remain in IDLE; Ptr is unchanged.

## Timing
- Reset values:
  - state=IDLE, Ptr=0, BeatCnt=0
  - {S2,S1,S0}=000, Gnt=00000000
  - Valid=0, Busy=0.
- Reset asserted mid-grant returns every register to its reset value on the next rising edge. No beat is counted in that cycle, even if Ready=1.
- Arbitration latency is 1 cycle. Example: Req sampled high at edge k gives Gnt, S, Busy at edge k+1, with Valid in the same cycle if Req is still high.
- A grant ends with one mandatory IDLE cycle. Back-to-back requesters therefore see a 1-cycle bubble. Maximum occupancy per requester is HOLD_MAX accepted beats followed by 1 idle cycle.
- Fairness: with all eight Req bits held high, grants rotate 0,1,…,7,0 with no starvation. The worst-case wait is 7 × (HOLD_MAX stalled-free beats + 1) cycles plus Ready stalls.
- Simultaneous release and accept (Req[winner] drops while Ready=1): release wins, so no beat is counted and the state moves to IDLE.
- BeatCnt never exceeds HOLD_MAX-1, so the 4-bit width is sufficient for HOLD_MAX ≤ 15.

## Structure
- Shared package mux_arb_pkg holds:
  - the state typedef (IDLE, GRANT)
  - HOLD_MAX default
  - the constant NREQ=8
  - the select width SEL_W=3.
- One sub-module, rr_pick8: purely combinational. Inputs are Req[7:0] and Ptr[2:0]. Outputs are winner[2:0] and any. Instantiated once.
- The top level contains the FSM, Ptr, BeatCnt and the output registers. It drives the existing 8:1 mux select pins directly.

## Test plan
- Single request: Reset, then Req=00001000 held, Ready=1, HOLD_MAX=4.
  - Next cycle: {S2,S1,S0}=011, Gnt=00001000, Valid=1.
  - 4 beats accepted, then IDLE for 1 cycle, then re-grant to 3 (the only requester), with Ptr=4 in between.
- Rotation: Req=11111111 held, Ready=1.
  - Winners sequence 0,1,…,7,0.
  - Each grant lasts exactly HOLD_MAX cycles followed by 1 idle cycle.
- Early release: Req[5] dropped after 2 accepted beats (HOLD_MAX=4).
  - Valid falls the same cycle; Gnt=0 next edge.
  - BeatCnt final value is 2; Ptr=6.
- Stall: Ready held low for 10 cycles during a grant to requester 2.
  - Gnt, S=010 and BeatCnt are unchanged.
  - After Ready rises, exactly HOLD_MAX beats are accepted before release.
- Priority wrap: Ptr=7 (after a grant to 6), Req=00000011.
  - Winner is 0, because the search wraps from 7 to 0.
- Reset mid-grant: assert Reset during beat 2 of a grant to requester 4 with Ready=1.
  - Next edge: Gnt=0, S=000, Valid=0, Ptr=0.
  - No extra beat is counted.
